// File: rtl/rom_arbiter.sv
// Round-robin front end sharing one single-port synchronous ROM between an
// instruction-fetch requester (0) and a data-load requester (1).
module rom_arbiter #(
    parameter int width     = 64,
    parameter int depth     = 64,
    parameter int addr_size = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_valid,
    input  logic [addr_size-1:0] req0_addr,
    output logic                 req0_ready,

    input  logic                 req1_valid,
    input  logic [addr_size-1:0] req1_addr,
    output logic                 req1_ready,

    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [width-1:0]     rsp_data,

    output logic [addr_size-1:0] rom_addr,
    input  logic [width-1:0]     rom_data
);

    logic                 pend_valid_q, pend_valid_d;
    logic                 pend_id_q,    pend_id_d;
    logic [addr_size-1:0] pend_addr_q,  pend_addr_d;
    logic                 last_grant_q, last_grant_d;

    logic                 issue_ok;
    logic                 any_valid;
    logic                 winner;
    logic                 grant;
    logic [addr_size-1:0] winner_addr;

    // A new read may issue when nothing is pending, or when the owner of the
    // pending response consumes it this cycle.
    always_comb begin
        issue_ok  = !pend_valid_q || (pend_id_q ? rsp1_ready : rsp0_ready);
        any_valid = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = req1_valid;
        end
        winner_addr = winner ? req1_addr : req0_addr;
        grant       = rst_n && issue_ok && any_valid;
    end

    assign req0_ready = grant && !winner;
    assign req1_ready = grant &&  winner;

    // Without a fresh grant the ROM keeps re-reading the pending word, so its
    // registered output stays stable under backpressure and while idle.
    assign rom_addr = grant ? winner_addr : pend_addr_q;

    assign rsp0_valid = pend_valid_q && !pend_id_q;
    assign rsp1_valid = pend_valid_q &&  pend_id_q;
    assign rsp_data   = rom_data;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        pend_addr_d  = pend_addr_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            pend_valid_d = 1'b1;
            pend_id_d    = winner;
            pend_addr_d  = winner_addr;
            last_grant_d = winner;
        end else if (issue_ok) begin
            pend_valid_d = 1'b0;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_id_q    <= 1'b0;
            pend_addr_q  <= '0;
            last_grant_q <= 1'b1;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            pend_addr_q  <= pend_addr_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: stimulus pushes hand-computed responses,
// a negedge monitor compares every presented response against the queue head.
module tb_rom_arbiter;

    localparam int WIDTH = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [AW-1:0]    req0_addr, req1_addr;
    logic             req0_ready, req1_ready;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_data;

    exp_t sb[$];
    int   assertCount = 0;
    int   failCount   = 0;

    rom_arbiter #(.width(WIDTH), .depth(DEPTH), .addr_size(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    always #5 clk = ~clk;

    // ROM image rom[k] = 0x1000 + k with one-cycle registered read.
    always @(posedge clk) rom_data <= 64'h1000 + {58'd0, rom_addr};

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus; handshakes are predicted from the expected
    // ready values, never from the DUT.
    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0,
                                 input logic v1, input logic [AW-1:0] a1,
                                 input logic r0, input logic r1,
                                 input logic expRdy0, input logic expRdy1);
        exp_t e;
        req0_valid = v0;
        req0_addr  = a0;
        req1_valid = v1;
        req1_addr  = a1;
        rsp0_ready = r0;
        rsp1_ready = r1;
        @(negedge clk);
        checkOutput("req0_ready", {63'd0, req0_ready}, {63'd0, expRdy0});
        checkOutput("req1_ready", {63'd0, req1_ready}, {63'd0, expRdy1});
        if (expRdy0 && v0) begin
            e.id = 1'b0; e.data = 64'h1000 + {58'd0, a0};
            sb.push_back(e);
        end
        if (expRdy1 && v1) begin
            e.id = 1'b1; e.data = 64'h1000 + {58'd0, a1};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented response must match the queue head (which
    // also checks stability while stalled); pop only when consumed.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
                checkOutput("one rsp_valid", {63'd0, rsp0_valid && rsp1_valid}, 64'd0);
                if (sb.size() == 0) begin
                    checkOutput("rsp with empty scoreboard", 64'(sb.size()), 64'd1);
                end else begin
                    checkOutput("rsp owner", {63'd0, rsp1_valid}, {63'd0, sb[0].id});
                    checkOutput("rsp_data", rsp_data, sb[0].data);
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
                        void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = '0;
        req1_valid = 1'b0; req1_addr = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset held with both requesters valid.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 6'd5, 1'b1, 6'd9, 1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("rsp0_valid in reset", {63'd0, rsp0_valid}, 64'd0);
            checkOutput("rsp1_valid in reset", {63'd0, rsp1_valid}, 64'd0);
        end
        checkOutput("rom_addr after reset", {58'd0, rom_addr}, 64'd0);
        rst_n = 1'b1;

        // Contention: first tie goes to 0, then alternate.
        applyStimulus(1'b1, 6'd5, 1'b1, 6'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'd5, 1'b1, 6'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 6'd5, 1'b1, 6'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'd5, 1'b1, 6'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 6'd5, 1'b1, 6'd9, 1'b1, 1'b1, 1'b1, 1'b0);

        // Single-port streaming over the full address range.
        for (int k = 0; k < DEPTH; k++)
            applyStimulus(1'b1, 6'(k), 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Backpressure on requester 1 while requester 0 waits.
        applyStimulus(1'b0, 6'd0, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 6'd2, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("rom_addr stalled", {58'd0, rom_addr}, 64'd7);
        end
        applyStimulus(1'b1, 6'd2, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Idle hold: drain the last response, address stays put.
        applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("idle rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
        checkOutput("idle rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
        checkOutput("idle rom_addr", {58'd0, rom_addr}, 64'd2);

        // Reset during the response cycle discards the in-flight read.
        applyStimulus(1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b1, 6'd3, 1'b1, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        sb.delete();
        rst_n = 1'b1;
        checkOutput("rsp0_valid after mid reset", {63'd0, rsp0_valid}, 64'd0);
        applyStimulus(1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-requester front end for the single-port synchronous ROM (`sp_rom`, one-cycle registered read). It shares the ROM's one address port between requester 0, the instruction-fetch side, and requester 1, the data-load side. Arbitration is round-robin with valid/ready handshakes on both request and response. Response backpressure is absorbed by holding the ROM address, so the ROM re-reads the same word and its output stays stable.

## Interface
- `width`, 64, ROM word width in bits
- `depth`, 64, ROM depth in words
- `addr_size`, `$clog2(depth)`, address width

Ports:
- `clk`  in  1  system clock; all state updates on posedge
- `rst_n`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `req0_valid`  in  1  requester 0 has an address to read
- `req0_addr`  in  addr_size  requester 0 read address
- `req0_ready`  out  1  requester 0 request accepted this cycle
- `req1_valid`, `req1_addr`, `req1_ready`  same roles for requester 1
- `rsp0_valid`  out  1  `rsp_data` holds requester 0's read result
- `rsp0_ready`  in  1  requester 0 consumes the response
- `rsp1_valid`, `rsp1_ready`  same roles for requester 1
- `rsp_data`  out  width  shared response data; connected directly to `rom_data`
- `rom_addr`  out  addr_size  drives the ROM `addr` port
- `rom_data`  in  width  driven by the ROM `data` port

## Operation
**State registers**
- `pend_valid`: a read is in flight or being presented.
- `pend_id`: owner of that read.
- `pend_addr`: address of that read.
- `last_grant`: requester granted most recently.

**Issue permission**
- `issue_ok = !pend_valid || rsp<pend_id>_ready`.
- A pending response therefore drains and a new read issues in the same cycle.

**Arbitration** (combinational, evaluated only when `issue_ok`)
- Only one valid: that requester wins.
- Both valid: the requester that is not `last_grant` wins.
- `req<i>_ready = issue_ok && winner==i`. Ready for the losing port is 0.
- Valid-before-ready is allowed. Requesters must hold `valid` and `addr` until ready.

**ROM address**
- `issue_ok`: `rom_addr` is the winner's address. If no requester is valid, `rom_addr` is `pend_addr`, which keeps the ROM output stable.
- Stalled (`!issue_ok`): `rom_addr = pend_addr`, so the ROM re-reads the same word and `rom_data` is unchanged.

**On each posedge (`rst_n` = 1)**
- Handshake with requester i:
  - `pend_valid` <= 1, `pend_id` <= i, `pend_addr` <= `req<i>_addr`
  - `last_grant` <= i
- Otherwise, if `issue_ok`: `pend_valid` <= 0.
- Otherwise (stalled): all state is held.

**Response**
- `rsp<i>_valid = pend_valid && pend_id==i`.
- `rsp_data = rom_data`.
- At most one `rsp*_valid` is high in any cycle.

**Reset** (`rst_n` = 0 at posedge)
- `pend_valid` <= 0, `pend_id` <= 0, `pend_addr` <= 0, `last_grant` <= 1. Requester 0 therefore wins the first tie.
- Reset mid-transaction discards the in-flight read; no response is produced for it.
- `req*_ready` is 0 while `rst_n` is low.

## Timing
**Reset values of outputs:** `req0_ready`, `req1_ready`, `rsp0_valid`, `rsp1_valid` = 0. `rom_addr` = 0. `rsp_data` is the stale ROM output and is don't-care while no response is valid.

**Cycle behaviour**
- Latency: handshake at edge T → `rsp_valid` and correct `rsp_data` during cycle T+1, which is the ROM's one-cycle latency.
- Throughput: one read per cycle sustained while the owning `rsp_ready` is held high.
- Both requesters valid continuously with both `rsp_ready` high: grants alternate 0,1,0,1,...
- Backpressure: `rsp_valid` and `rsp_data` remain stable for every cycle `rsp_ready` is low. No new request is accepted from either port while the pending response is unconsumed.

**Simultaneous events**
- Response consumed and new request accepted in the same cycle is legal. `pend_id` may switch owner at that edge.
- A requester may receive its own response and issue its next request in the same cycle.

**Boundaries**
- Addresses 0 and `depth`-1 pass through unmodified; no wrap logic.
- `req*_addr` ≥ `depth` (only possible when `depth` is not a power of two) is undefined.

## Test plan
ROM image for all scenarios: `rom[k] = 0x1000 + k`.

1. **Reset:** hold `rst_n`=0 for 3 cycles with both requesters valid → both ready and both rsp_valid stay 0. First cycle after release: `req0_ready`=1, `req1_ready`=0.
2. **Single-port streaming:** `req0` valid, addresses 0,1,2,...,63 back-to-back, `rsp0_ready`=1 → one accept per cycle. `rsp_data` 0x1000..0x103F, each one cycle after its accept. Addresses 0 and 63 are correct.
3. **Contention:** both valid continuously (req0 addr 5, req1 addr 9), both rsp_ready=1 → grants alternate 0,1,0,1. Responses alternate `rsp0_valid`/0x1005 and `rsp1_valid`/0x1009.
4. **Backpressure:** `req1` accepted at addr 7, then `rsp1_ready`=0 for 4 cycles while `req0` is valid → `rsp1_valid`=1, `rsp_data`=0x1007 stable for 4 cycles, `req0_ready`=0. When `rsp1_ready` rises, `req0` is accepted in that same cycle.
5. **Reset mid-operation:** accept `req0` addr 3, assert `rst_n`=0 in the response cycle → `rsp0_valid` is 0 after the edge, no late response appears, and the tie priority returns to requester 0.
6. **Idle hold:** one response consumed with no further requests → `pend_valid` falls, all valid/ready outputs are 0, and `rom_addr` holds the last address.
